// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Sequencer for the multicycle datapath. Decodes the instruction register and
//   walks each instruction through FETCH/DECODE/EXEC/MEM/WB, driving the
//   register-file, ALU, PC and memory strobes. Memory accesses use a
//   variable-latency ready handshake guarded by a timeout; bus timeouts and
//   illegal encodings park the sequencer in ERROR until reset.
//
// Ports
//   i_clk            clock, rising edge
//   i_reset_n        asynchronous active-low reset
//   i_instr          instruction register contents (valid from DECODE on)
//   i_mem_ready      memory completes the current request this cycle
//   i_alu_zero       ALU zero flag (valid in EXEC)
//   o_mem_req        memory request (fetch or data)
//   o_mem_we         memory write (SW in MEM only)
//   o_ir_write       load instruction register
//   o_pc_write       update PC this cycle
//   o_pc_select      00 PC+4, 01 branch target, 10 jump target, 11 rs
//   o_reg_write      register file write strobe
//   o_reg_dst        1: rd, 0: rt
//   o_write_reg31    write target forced to r31
//   o_alu_src        ALU B source (00 rt data, 01 sext imm16, 10 zext imm16,
//                    11 shift: A from rt, B from shamt)
//   o_alu_op         ALU operation (0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 SLL,6 SRL)
//   o_mem_to_reg     write-back from memory data
//   o_state          current state (debug)
//   o_bus_error      sticky memory-timeout flag
//   o_illegal_instr  sticky illegal-encoding flag
//   o_instr_count    retired instructions, wraps to 0
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter int ENABLE_LINK = 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [31:0]      i_instr,
    input  logic             i_mem_ready,
    input  logic             i_alu_zero,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic             o_ir_write,
    output logic             o_pc_write,
    output logic [1:0]       o_pc_select,
    output logic             o_reg_write,
    output logic             o_reg_dst,
    output logic             o_write_reg31,
    output logic [1:0]       o_alu_src,
    output logic [2:0]       o_alu_op,
    output logic             o_mem_to_reg,
    output logic [2:0]       o_state,
    output logic             o_bus_error,
    output logic             o_illegal_instr,
    output logic [CNT_W-1:0] o_instr_count
);

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;
    localparam logic [5:0] OPCODE_J     = 6'h02;
    localparam logic [5:0] OPCODE_JAL   = 6'h03;
    localparam logic [5:0] OPCODE_BEQ   = 6'h04;
    localparam logic [5:0] OPCODE_BNE   = 6'h05;
    localparam logic [5:0] OPCODE_ADDI  = 6'h08;
    localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
    localparam logic [5:0] OPCODE_ORI   = 6'h0D;
    localparam logic [5:0] OPCODE_LW    = 6'h23;
    localparam logic [5:0] OPCODE_SW    = 6'h2B;

    localparam logic [5:0] FUNC_SLL  = 6'h00;
    localparam logic [5:0] FUNC_SRL  = 6'h02;
    localparam logic [5:0] FUNC_JR   = 6'h08;
    localparam logic [5:0] FUNC_JALR = 6'h09;
    localparam logic [5:0] FUNC_ADD  = 6'h20;
    localparam logic [5:0] FUNC_SUB  = 6'h22;
    localparam logic [5:0] FUNC_AND  = 6'h24;
    localparam logic [5:0] FUNC_OR   = 6'h25;
    localparam logic [5:0] FUNC_SLT  = 6'h2A;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;

    localparam logic [1:0] ALU_SRC_DATA_B     = 2'd0;
    localparam logic [1:0] ALU_SRC_SEXT_IMM16 = 2'd1;
    localparam logic [1:0] ALU_SRC_ZEXT_IMM16 = 2'd2;
    localparam logic [1:0] ALU_SRC_SHIFT      = 2'd3;

    localparam logic [1:0] PC_SEL_PC4    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
    localparam logic [1:0] PC_SEL_RS     = 2'b11;

    localparam int              WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERROR  = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        CLS_ILLEGAL, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BEQ, CLS_BNE,
        CLS_J, CLS_JAL, CLS_JR, CLS_JALR
    } class_e;

    state_e             r_state;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_bus_error;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_count;

    logic [5:0] w_op;
    logic [5:0] w_func;
    class_e     w_class;
    logic       w_is_rtype;
    logic [2:0] w_alu_op;
    logic [1:0] w_alu_src;
    logic       w_unused;

    assign w_op     = i_instr[31:26];
    assign w_func   = i_instr[5:0];
    assign w_unused = ^i_instr[25:6];

    // Instruction classification plus the ALU setting each class needs in EXEC/MEM.
    // Link forms fall through to CLS_ILLEGAL when linking is disabled.
    always_comb begin
        w_class    = CLS_ILLEGAL;
        w_alu_op   = OP_ADD;
        w_alu_src  = ALU_SRC_DATA_B;
        w_is_rtype = (w_op == OPCODE_RTYPE);
        case (w_op)
            OPCODE_RTYPE: begin
                case (w_func)
                    FUNC_ADD: w_class = CLS_ALU;
                    FUNC_SUB: begin w_class = CLS_ALU; w_alu_op = OP_SUB; end
                    FUNC_AND: begin w_class = CLS_ALU; w_alu_op = OP_AND; end
                    FUNC_OR:  begin w_class = CLS_ALU; w_alu_op = OP_OR;  end
                    FUNC_SLT: begin w_class = CLS_ALU; w_alu_op = OP_SLT; end
                    // Shifts take A from rt and B from shamt.
                    FUNC_SLL: begin w_class = CLS_ALU; w_alu_op = OP_SLL; w_alu_src = ALU_SRC_SHIFT; end
                    FUNC_SRL: begin w_class = CLS_ALU; w_alu_op = OP_SRL; w_alu_src = ALU_SRC_SHIFT; end
                    FUNC_JR:  w_class = CLS_JR;
                    FUNC_JALR: if (ENABLE_LINK != 0) w_class = CLS_JALR;
                    default: ;
                endcase
            end
            OPCODE_J:   w_class = CLS_J;
            OPCODE_JAL: if (ENABLE_LINK != 0) w_class = CLS_JAL;
            OPCODE_BEQ: begin w_class = CLS_BEQ; w_alu_op = OP_SUB; end
            OPCODE_BNE: begin w_class = CLS_BNE; w_alu_op = OP_SUB; end
            OPCODE_ADDI: begin w_class = CLS_ALU; w_alu_src = ALU_SRC_SEXT_IMM16; end
            OPCODE_ANDI: begin w_class = CLS_ALU; w_alu_op = OP_AND; w_alu_src = ALU_SRC_ZEXT_IMM16; end
            OPCODE_ORI:  begin w_class = CLS_ALU; w_alu_op = OP_OR;  w_alu_src = ALU_SRC_ZEXT_IMM16; end
            OPCODE_LW:   begin w_class = CLS_LOAD;  w_alu_src = ALU_SRC_SEXT_IMM16; end
            OPCODE_SW:   begin w_class = CLS_STORE; w_alu_src = ALU_SRC_SEXT_IMM16; end
            default: ;
        endcase
    end

    // Sequencer state, memory wait counter, sticky flags and retire counter.
    // The wait counter is cleared on every transition into FETCH or MEM; a
    // ready on the final allowed wait cycle still completes the request.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_bus_error <= 1'b0;
            r_illegal   <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_wait  <= '0;
                end
                S_FETCH: begin
                    if (i_mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (r_wait == WAIT_LAST) begin
                        r_state     <= S_ERROR;
                        r_bus_error <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    case (w_class)
                        CLS_J, CLS_JAL: begin
                            r_state <= S_FETCH;
                            r_wait  <= '0;
                            r_count <= r_count + CNT_W'(1);
                        end
                        CLS_ILLEGAL: begin
                            r_state   <= S_ERROR;
                            r_illegal <= 1'b1;
                        end
                        default: r_state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (w_class)
                        CLS_LOAD, CLS_STORE: begin
                            r_state <= S_MEM;
                            r_wait  <= '0;
                        end
                        CLS_BEQ, CLS_BNE, CLS_JR, CLS_JALR: begin
                            r_state <= S_FETCH;
                            r_wait  <= '0;
                            r_count <= r_count + CNT_W'(1);
                        end
                        default: r_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (i_mem_ready) begin
                        if (w_class == CLS_STORE) begin
                            r_state <= S_FETCH;
                            r_wait  <= '0;
                            r_count <= r_count + CNT_W'(1);
                        end else begin
                            r_state <= S_WB;
                        end
                    end else if (r_wait == WAIT_LAST) begin
                        r_state     <= S_ERROR;
                        r_bus_error <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_wait  <= '0;
                    r_count <= r_count + CNT_W'(1);
                end
                S_ERROR: r_state <= S_ERROR;
                default: r_state <= S_ERROR;
            endcase
        end
    end

    // Strobes are decoded combinationally from the current state so that
    // reset removes mem_req in the same cycle it is asserted.
    always_comb begin
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_ir_write    = 1'b0;
        o_pc_write    = 1'b0;
        o_pc_select   = PC_SEL_PC4;
        o_reg_write   = 1'b0;
        o_reg_dst     = 1'b0;
        o_write_reg31 = 1'b0;
        o_alu_src     = ALU_SRC_DATA_B;
        o_alu_op      = OP_ADD;
        o_mem_to_reg  = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                if (w_class == CLS_J || w_class == CLS_JAL) begin
                    o_pc_write  = 1'b1;
                    o_pc_select = PC_SEL_JUMP;
                end
                if (w_class == CLS_JAL) begin
                    o_reg_write   = 1'b1;
                    o_write_reg31 = 1'b1;
                end
            end
            S_EXEC: begin
                o_alu_op  = w_alu_op;
                o_alu_src = w_alu_src;
                o_reg_dst = w_is_rtype;
                case (w_class)
                    CLS_BEQ: begin o_pc_write = i_alu_zero;  o_pc_select = PC_SEL_BRANCH; end
                    CLS_BNE: begin o_pc_write = !i_alu_zero; o_pc_select = PC_SEL_BRANCH; end
                    CLS_JR:  begin o_pc_write = 1'b1; o_pc_select = PC_SEL_RS; end
                    CLS_JALR: begin
                        o_pc_write    = 1'b1;
                        o_pc_select   = PC_SEL_RS;
                        o_reg_write   = 1'b1;
                        o_write_reg31 = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                o_mem_req = 1'b1;
                o_mem_we  = (w_class == CLS_STORE);
                o_alu_op  = w_alu_op;
                o_alu_src = w_alu_src;
            end
            S_WB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = (w_class == CLS_LOAD);
                o_reg_dst    = w_is_rtype;
            end
            default: ;
        endcase
    end

    assign o_state         = r_state;
    assign o_bus_error     = r_bus_error;
    assign o_illegal_instr = r_illegal;
    assign o_instr_count   = r_count;

endmodule
